tob_frame_tx: RTL and testbench

TOB_FRAME_TX -- requirements
Module: tob_frame_tx

---
 rtl/tob_frame_tx_if.sv | 28 ++
 rtl/tob_frame_tx.sv | 159 +++++++++++++++
 tb/tb_tob_frame_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tob_frame_tx_if.sv
// Book-update inputs and byte-stream output of the top-of-book frame transmitter.
interface tob_frame_tx_if;
    logic        buyUpdatedIn;
    logic [31:0] buyPriceIn;
    logic [31:0] buyQuantIn;
    logic        sellUpdatedIn;
    logic [31:0] sellPriceIn;
    logic [31:0] sellQuantIn;
    logic [7:0]  txDataOut;
    logic        txValidOut;
    logic        txLastOut;
    logic        txReadyIn;
    logic [15:0] coalesceCntOut;

    modport master (
        output buyUpdatedIn, buyPriceIn, buyQuantIn,
        output sellUpdatedIn, sellPriceIn, sellQuantIn,
        output txReadyIn,
        input  txDataOut, txValidOut, txLastOut, coalesceCntOut
    );

    modport slave (
        input  buyUpdatedIn, buyPriceIn, buyQuantIn,
        input  sellUpdatedIn, sellPriceIn, sellQuantIn,
        input  txReadyIn,
        output txDataOut, txValidOut, txLastOut, coalesceCntOut
    );
endinterface

// File: rtl/tob_frame_tx.sv
// Packs the latest buy/sell top-of-book snapshots into 30-byte Ethernet frames,
// alternating sides on contention and coalescing updates that arrive while busy.
module tob_frame_tx #(
    parameter logic [47:0] DEST_MAC = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC  = 48'h000A35000001,
    parameter logic [15:0] ETH_TYPE = 16'h88B5,
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input logic           clkIn,
    input logic           rstBIn,
    tob_frame_tx_if.slave bus
);
    localparam logic [4:0] LAST_IDX  = 5'd29;
    localparam logic       SIDE_BUY  = 1'b0;
    localparam logic       SIDE_SELL = 1'b1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;

    logic        buy_vld, sell_vld;
    logic [31:0] buy_price, buy_quant, sell_price, sell_quant;
    logic        last_side;
    logic [15:0] seq;
    logic [15:0] coal_cnt;
    logic [4:0]  byte_idx;

    logic        frame_side;
    logic [15:0] frame_seq;
    logic [31:0] frame_price, frame_quant;

    logic        load, load_sell, accept;
    logic        buy_coal, sell_coal;
    logic [7:0]  tx_byte;

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_sell = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (buy_vld || sell_vld) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                    // On a tie, serve the side that was not sent last.
                    load_sell = sell_vld && (!buy_vld || last_side == SIDE_BUY);
                end
            end
            SEND: begin
                accept = bus.txReadyIn;
                if (bus.txReadyIn && byte_idx == LAST_IDX)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rstBIn) state <= IDLE;
        else         state <= state_nxt;
    end

    // A fresh update on the side being loaded refills the slot and is not a coalesce.
    assign buy_coal  = bus.buyUpdatedIn  && buy_vld  && !(load && !load_sell);
    assign sell_coal = bus.sellUpdatedIn && sell_vld && !(load && load_sell);

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            buy_vld  <= 1'b0;
            sell_vld <= 1'b0;
            coal_cnt <= 16'h0000;
        end else begin
            if (bus.buyUpdatedIn)         buy_vld <= 1'b1;
            else if (load && !load_sell)  buy_vld <= 1'b0;
            if (bus.sellUpdatedIn)        sell_vld <= 1'b1;
            else if (load && load_sell)   sell_vld <= 1'b0;
            coal_cnt <= sat_add16(coal_cnt, {1'b0, buy_coal} + {1'b0, sell_coal});
        end
    end

    always_ff @(posedge clkIn) begin
        if (bus.buyUpdatedIn) begin
            buy_price <= bus.buyPriceIn;
            buy_quant <= bus.buyQuantIn;
        end
        if (bus.sellUpdatedIn) begin
            sell_price <= bus.sellPriceIn;
            sell_quant <= bus.sellQuantIn;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            byte_idx  <= 5'd0;
            seq       <= SEQ_INIT;
            last_side <= SIDE_SELL;
        end else if (load) begin
            byte_idx  <= 5'd0;
            seq       <= seq + 16'd1;
            last_side <= load_sell;
        end else if (accept) begin
            byte_idx  <= (byte_idx == LAST_IDX) ? 5'd0 : byte_idx + 5'd1;
        end
    end

    // The in-flight frame only changes on a load, so updates during SEND never disturb it.
    always_ff @(posedge clkIn) begin
        if (load) begin
            frame_side  <= load_sell;
            frame_seq   <= seq;
            frame_price <= load_sell ? sell_price : buy_price;
            frame_quant <= load_sell ? sell_quant : buy_quant;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            5'd0:    tx_byte = DEST_MAC[47:40];
            5'd1:    tx_byte = DEST_MAC[39:32];
            5'd2:    tx_byte = DEST_MAC[31:24];
            5'd3:    tx_byte = DEST_MAC[23:16];
            5'd4:    tx_byte = DEST_MAC[15:8];
            5'd5:    tx_byte = DEST_MAC[7:0];
            5'd6:    tx_byte = SRC_MAC[47:40];
            5'd7:    tx_byte = SRC_MAC[39:32];
            5'd8:    tx_byte = SRC_MAC[31:24];
            5'd9:    tx_byte = SRC_MAC[23:16];
            5'd10:   tx_byte = SRC_MAC[15:8];
            5'd11:   tx_byte = SRC_MAC[7:0];
            5'd12:   tx_byte = ETH_TYPE[15:8];
            5'd13:   tx_byte = ETH_TYPE[7:0];
            5'd14:   tx_byte = 8'h54;
            5'd15:   tx_byte = frame_side ? 8'h53 : 8'h42;
            5'd16:   tx_byte = frame_seq[15:8];
            5'd17:   tx_byte = frame_seq[7:0];
            5'd18:   tx_byte = frame_price[31:24];
            5'd19:   tx_byte = frame_price[23:16];
            5'd20:   tx_byte = frame_price[15:8];
            5'd21:   tx_byte = frame_price[7:0];
            5'd22:   tx_byte = frame_quant[31:24];
            5'd23:   tx_byte = frame_quant[23:16];
            5'd24:   tx_byte = frame_quant[15:8];
            5'd25:   tx_byte = frame_quant[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    assign bus.txValidOut     = (state == SEND);
    assign bus.txDataOut      = (state == SEND) ? tx_byte : 8'h00;
    assign bus.txLastOut      = (state == SEND) && (byte_idx == LAST_IDX);
    assign bus.coalesceCntOut = coal_cnt;
endmodule

// File: tb/tb_tob_frame_tx.sv
// Randomised and directed bench for tob_frame_tx against a frame-level reference model.
module tb_tob_frame_tx;
    localparam logic [47:0] DEST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC  = 48'h000A35000001;
    localparam logic [15:0] TYPE = 16'h88B5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tob_frame_tx_if bus ();
    tob_frame_tx_if bus_w ();

    tob_frame_tx dut (.clkIn(clk), .rstBIn(rst_n), .bus(bus));
    // Second instance starts its sequence at FFFF so the wrap is reached on its second frame.
    tob_frame_tx #(.SEQ_INIT(16'hFFFF)) dut_w (.clkIn(clk), .rstBIn(rst_n), .bus(bus_w));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cap_q[$];
    logic       last_q[$];
    logic [7:0] wcap_q[$];
    logic       vh[$];

    // Reference model: pending snapshot per side (0 = buy, 1 = sell) and a frame image.
    logic         m_busy;
    int           m_idx;
    logic [239:0] m_frame;
    logic         m_pv[2];
    logic [31:0]  m_pp[2];
    logic [31:0]  m_pq[2];
    logic         m_last;
    logic [15:0]  m_seq;
    logic [15:0]  m_coal;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [239:0] build(input logic side, input logic [15:0] sq,
                                           input logic [31:0] p, input logic [31:0] q);
        return {DEST, SRC, TYPE, 8'h54, (side ? 8'h53 : 8'h42), sq, p, q, 32'h0};
    endfunction

    task automatic model_edge(input logic rn, input logic rdy,
                              input logic bu, input logic [31:0] bp, input logic [31:0] bq,
                              input logic su, input logic [31:0] sp, input logic [31:0] sq);
        logic ld;
        logic side;
        logic upd[2];
        logic [31:0] up[2];
        logic [31:0] uq[2];
        if (!rn) begin
            m_busy = 1'b0; m_idx = 0; m_pv[0] = 1'b0; m_pv[1] = 1'b0;
            m_seq = 16'h0; m_last = 1'b1; m_coal = 16'h0;
            return;
        end
        upd[0] = bu; up[0] = bp; uq[0] = bq;
        upd[1] = su; up[1] = sp; uq[1] = sq;
        ld = !m_busy && (m_pv[0] || m_pv[1]);
        side = 1'b0;
        if (ld) begin
            if (m_pv[0] && m_pv[1]) side = !m_last;
            else                    side = m_pv[1];
            m_frame = build(side, m_seq, m_pp[side], m_pq[side]);
            m_seq = m_seq + 16'd1;
            m_last = side;
            m_busy = 1'b1;
            m_idx = 0;
            m_pv[side] = 1'b0;
        end else if (m_busy && rdy) begin
            if (m_idx == 29) m_busy = 1'b0;
            else             m_idx++;
        end
        for (int s = 0; s < 2; s++) begin
            if (upd[s]) begin
                if (m_pv[s] && m_coal != 16'hFFFF) m_coal = m_coal + 16'd1;
                m_pv[s] = 1'b1;
                m_pp[s] = up[s];
                m_pq[s] = uq[s];
            end
        end
    endtask

    task automatic step();
        logic rn, rdy, bu, su;
        logic [31:0] bp, bq, sp, sq;
        if (bus.txValidOut === 1'b1 && bus.txReadyIn) begin
            cap_q.push_back(bus.txDataOut);
            last_q.push_back(bus.txLastOut);
        end
        if (bus_w.txValidOut === 1'b1 && bus_w.txReadyIn) wcap_q.push_back(bus_w.txDataOut);
        rn = rst_n; rdy = bus.txReadyIn;
        bu = bus.buyUpdatedIn;  bp = bus.buyPriceIn;  bq = bus.buyQuantIn;
        su = bus.sellUpdatedIn; sp = bus.sellPriceIn; sq = bus.sellQuantIn;
        @(posedge clk);
        model_edge(rn, rdy, bu, bp, bq, su, sp, sq);
        #1;
        check("valid", bus.txValidOut, m_busy);
        if (m_busy) begin
            check("data", bus.txDataOut, m_frame[239-8*m_idx -: 8]);
            check("last", bus.txLastOut, m_idx == 29);
        end else begin
            check("last_idle", bus.txLastOut, 1'b0);
        end
        check("coalesce", bus.coalesceCntOut, m_coal);
        vh.push_back(bus.txValidOut);
        bus.buyUpdatedIn = 1'b0;
        bus.sellUpdatedIn = 1'b0;
        bus_w.buyUpdatedIn = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cap_q.delete(); last_q.delete(); vh.delete();
    endtask

    task automatic pulse_buy(input logic [31:0] p, input logic [31:0] q);
        bus.buyUpdatedIn = 1'b1; bus.buyPriceIn = p; bus.buyQuantIn = q;
    endtask

    task automatic pulse_sell(input logic [31:0] p, input logic [31:0] q);
        bus.sellUpdatedIn = 1'b1; bus.sellPriceIn = p; bus.sellQuantIn = q;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int nlast, i0, j, gap;
        bus.buyUpdatedIn = 0; bus.buyPriceIn = 0; bus.buyQuantIn = 0;
        bus.sellUpdatedIn = 0; bus.sellPriceIn = 0; bus.sellQuantIn = 0;
        bus.txReadyIn = 1'b1;
        bus_w.buyUpdatedIn = 0; bus_w.buyPriceIn = 0; bus_w.buyQuantIn = 0;
        bus_w.sellUpdatedIn = 0; bus_w.sellPriceIn = 0; bus_w.sellQuantIn = 0;
        bus_w.txReadyIn = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_valid", bus.txValidOut, 1'b0);
        check("rst_last", bus.txLastOut, 1'b0);
        check("rst_data", bus.txDataOut, 8'h00);
        check("rst_coal", bus.coalesceCntOut, 16'h0);
        rst_n = 1'b1;
        step();
        cap_q.delete(); last_q.delete();

        // Single buy frame, ready held high
        pulse_buy(32'h0022FEFC, 32'h00000045);
        step();
        check("lat_edge1", bus.txValidOut, 1'b0);
        step();
        check("lat_edge2", bus.txValidOut, 1'b1);
        repeat (35) step();
        check("f1_len", cap_q.size(), 30);
        if (cap_q.size() == 30) begin
            check("f1_dest", {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5]}, DEST);
            check("f1_type", {cap_q[12], cap_q[13]}, 16'h88B5);
            check("f1_tag", cap_q[14], 8'h54);
            check("f1_side", cap_q[15], 8'h42);
            check("f1_seq", {cap_q[16], cap_q[17]}, 16'h0000);
            check("f1_price", {cap_q[18], cap_q[19], cap_q[20], cap_q[21]}, 32'h0022FEFC);
            check("f1_quant", {cap_q[22], cap_q[23], cap_q[24], cap_q[25]}, 32'h00000045);
            nlast = 0;
            foreach (last_q[i]) if (last_q[i]) nlast++;
            check("f1_last_cnt", nlast, 1);
            check("f1_last_pos", last_q[29], 1'b1);
        end

        // Simultaneous buy and sell: BUY first, then SELL, one idle cycle apart
        do_reset();
        pulse_buy(32'h11111111, 32'h22);
        pulse_sell(32'h33333333, 32'h44);
        repeat (70) step();
        check("tie_len", cap_q.size(), 60);
        if (cap_q.size() == 60) begin
            check("tie_side0", cap_q[15], 8'h42);
            check("tie_seq0", {cap_q[16], cap_q[17]}, 16'h0000);
            check("tie_side1", cap_q[45], 8'h53);
            check("tie_seq1", {cap_q[46], cap_q[47]}, 16'h0001);
            check("tie_price1", {cap_q[48], cap_q[49], cap_q[50], cap_q[51]}, 32'h33333333);
        end
        i0 = 0;
        while (i0 < vh.size() && vh[i0] != 1'b1) i0++;
        j = i0;
        while (j < vh.size() && vh[j] == 1'b1) j++;
        gap = 0;
        while (j < vh.size() && vh[j] == 1'b0) begin gap++; j++; end
        check("tie_gap", gap, 1);

        // Three buy updates while a frame is in flight coalesce into one
        do_reset();
        pulse_buy(32'h00000100, 32'd100);
        repeat (5) step();
        for (int k = 1; k <= 3; k++) begin
            pulse_buy(32'h00000200, k);
            step();
        end
        repeat (70) step();
        check("coal_len", cap_q.size(), 60);
        if (cap_q.size() == 60) begin
            check("coal_q0", {cap_q[22], cap_q[23], cap_q[24], cap_q[25]}, 32'd100);
            check("coal_q1", {cap_q[52], cap_q[53], cap_q[54], cap_q[55]}, 32'd3);
        end
        check("coal_cnt", bus.coalesceCntOut, 16'd2);

        // Random updates with ready toggling
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.txReadyIn = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) pulse_buy($urandom, $urandom);
            if ($urandom_range(0, 15) == 0) pulse_sell($urandom, $urandom);
            step();
        end
        bus.txReadyIn = 1'b1;
        repeat (80) step();

        // Reset in the middle of a frame
        do_reset();
        pulse_buy(32'h0000ABCD, 32'h7);
        step();
        pulse_sell(32'h0000DCBA, 32'h8);
        for (int c = 0; c < 60 && cap_q.size() < 10; c++) step();
        check("abort_at10", cap_q.size(), 10);
        rst_n = 1'b0;
        step();
        check("abort_valid", bus.txValidOut, 1'b0);
        check("abort_last", bus.txLastOut, 1'b0);
        rst_n = 1'b1;
        repeat (5) step();
        check("abort_no_pending", bus.txValidOut, 1'b0);
        nlast = 0;
        foreach (last_q[i]) if (last_q[i]) nlast++;
        check("abort_no_last", nlast, 0);
        cap_q.delete(); last_q.delete();
        pulse_buy(32'h00001234, 32'h9);
        repeat (35) step();
        check("abort_next_len", cap_q.size(), 30);
        if (cap_q.size() == 30)
            check("abort_next_seq", {cap_q[16], cap_q[17]}, 16'h0000);

        // Sequence wrap on the FFFF-preset instance
        wcap_q.delete();
        bus_w.buyUpdatedIn = 1'b1; bus_w.buyPriceIn = 32'h5; bus_w.buyQuantIn = 32'h6;
        repeat (35) step();
        bus_w.buyUpdatedIn = 1'b1;
        repeat (35) step();
        check("wrap_len", wcap_q.size(), 60);
        if (wcap_q.size() == 60) begin
            check("wrap_seq_ffff", {wcap_q[16], wcap_q[17]}, 16'hFFFF);
            check("wrap_seq_0000", {wcap_q[46], wcap_q[47]}, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
